// File: rtl/cpu_bus_xfer.sv
// Splits a 1/2/4-byte core load/store into little-endian narrow bus beats,
// each beat using a four-phase strobe/ready handshake with per-wait timeout.
module cpu_bus_xfer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int BUS_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [1:0]        i_size,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_bus_clk,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [BUS_W-1:0]  o_bus_data,
  input  logic [BUS_W-1:0]  i_bus_data,
  input  logic              i_bus_data_ready
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_RELEASE
  } state_t;

  state_t            r_state;
  logic [1:0]        r_beat;
  logic [1:0]        r_last;
  logic [DATA_W-1:0] r_wdata;
  logic [TW-1:0]     r_tcnt;

  logic       w_illegal;
  logic       w_tmo;
  logic [1:0] w_last;

  assign w_illegal = (i_size == 2'd3) ||
                     ((BUS_W << i_size) > DATA_W);

  // Abort when the cycle now ending would be the TIMEOUT-th spent waiting.
  assign w_tmo = (TIMEOUT != 0) &&
                 ((32'(r_tcnt) + 32'd1) == 32'(TIMEOUT));

  always_comb begin
    w_last = 2'd0;
    unique case (i_size)
      2'd1:    w_last = 2'd1;
      2'd2:    w_last = 2'd3;
      default: w_last = 2'd0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_beat     <= '0;
      r_last     <= '0;
      r_wdata    <= '0;
      r_tcnt     <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_rdata    <= '0;
      o_bus_clk  <= 1'b0;
      o_bus_we   <= 1'b0;
      o_bus_addr <= '0;
      o_bus_data <= '0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_req) begin
            o_rdata <= '0;
            if (w_illegal) begin
              o_done <= 1'b1;
              o_err  <= 1'b1;
            end else begin
              o_busy     <= 1'b1;
              o_bus_clk  <= 1'b1;
              o_bus_we   <= i_we;
              o_bus_addr <= i_addr;
              o_bus_data <= i_wdata[BUS_W-1:0];
              r_wdata    <= i_wdata >> BUS_W;
              r_beat     <= '0;
              r_last     <= w_last;
              r_tcnt     <= '0;
              r_state    <= S_STROBE;
            end
          end
        end
        S_STROBE: begin
          if (i_bus_data_ready) begin
            if (!o_bus_we)
              o_rdata[r_beat*BUS_W +: BUS_W] <= i_bus_data;
            o_bus_clk <= 1'b0;
            r_tcnt    <= '0;
            r_state   <= S_RELEASE;
          end else if (w_tmo) begin
            o_bus_clk <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b1;
            o_err     <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_RELEASE: begin
          if (!i_bus_data_ready) begin
            r_tcnt <= '0;
            if (r_beat == r_last) begin
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_beat     <= r_beat + 1'b1;
              o_bus_addr <= o_bus_addr + 1'b1;
              o_bus_data <= r_wdata[BUS_W-1:0];
              r_wdata    <= r_wdata >> BUS_W;
              o_bus_clk  <= 1'b1;
              r_state    <= S_STROBE;
            end
          end else if (w_tmo) begin
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            o_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_xfer.sv
// Bench for cpu_bus_xfer: vector table, beat scoreboard checked by a
// wait-state slave model, plus timeout and mid-transfer reset sequences.
module tb_cpu_bus_xfer;

  logic        clk;
  logic        i_rst;
  logic        i_req;
  logic        i_we;
  logic [1:0]  i_size;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [31:0] o_rdata;
  logic        o_bus_clk;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [7:0]  o_bus_data;
  logic [7:0]  i_bus_data;
  logic        i_bus_data_ready;

  cpu_bus_xfer #(
    .ADDR_W(32), .DATA_W(32), .BUS_W(8), .TIMEOUT(255)
  ) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_req(i_req),
    .i_we(i_we),
    .i_size(i_size),
    .i_addr(i_addr),
    .i_wdata(i_wdata),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_err(o_err),
    .o_rdata(o_rdata),
    .o_bus_clk(o_bus_clk),
    .o_bus_we(o_bus_we),
    .o_bus_addr(o_bus_addr),
    .o_bus_data(o_bus_data),
    .i_bus_data(i_bus_data),
    .i_bus_data_ready(i_bus_data_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] sdat;
    int          ws;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_cyc;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [7:0]  wd;
    logic [7:0]  rd;
  } beat_t;

  beat_t bq[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    ws_cur = 0;
  bit    hang = 0;
  bit    seen = 0;
  int    wcnt = 0;
  int    nseen = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Slave: checks each new beat against the scoreboard, answers after ws_cur waits.
  always @(negedge clk) begin
    beat_t b;
    if (o_bus_clk) begin
      if (!seen) begin
        seen = 1;
        wcnt = 0;
        nseen++;
        if (bq.size() == 0) begin
          chk("unexpected_beat", 64'(o_bus_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          b = bq.pop_front();
          chk("beat_addr", 64'(o_bus_addr), 64'(b.addr));
          chk("beat_we", 64'(o_bus_we), 64'(b.we));
          if (b.we) chk("beat_data", 64'(o_bus_data), 64'(b.wd));
          i_bus_data = b.rd;
        end
      end
      if (!hang && wcnt >= ws_cur) i_bus_data_ready = 1'b1;
      else wcnt++;
    end else begin
      i_bus_data_ready = 1'b0;
      seen = 0;
    end
  end

  task automatic push_beats(input vec_t v);
    beat_t b;
    int nb;
    logic [31:0] w;
    logic [31:0] s;
    nb = (v.size == 2'd3) ? 0 : (1 << v.size);
    w = v.wdata;
    s = v.sdat;
    for (int i = 0; i < nb; i++) begin
      b.addr = v.addr + 32'(i);
      b.we   = v.we;
      b.wd   = w[8*i +: 8];
      b.rd   = s[8*i +: 8];
      bq.push_back(b);
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    ws_cur  = v.ws;
    push_beats(v);
    i_we    = v.we;
    i_size  = v.size;
    i_addr  = v.addr;
    i_wdata = v.wdata;
    i_req   = 1'b1;
    @(posedge clk);
    #1;
    i_req = 1'b0;
  endtask

  task automatic run(input vec_t v, input string nm);
    int cyc;
    drive(v);
    cyc = 0;
    if (v.size != 2'd3) chk({nm, "_busy"}, 64'(o_busy), 64'd1);
    while (!o_done && cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({nm, "_done"}, 64'(o_done), 64'd1);
    chk({nm, "_err"}, 64'(o_err), 64'(v.exp_err));
    chk({nm, "_cycles"}, 64'(cyc), 64'(v.exp_cyc));
    chk({nm, "_busy_end"}, 64'(o_busy), 64'd0);
    chk({nm, "_strobe_end"}, 64'(o_bus_clk), 64'd0);
    chk({nm, "_beats_left"}, 64'(bq.size()), 64'd0);
    if (!v.we && !v.exp_err)
      chk({nm, "_rdata"}, 64'(o_rdata), 64'(v.exp_rdata));
    @(posedge clk);
    #1;
    chk({nm, "_pulse"}, 64'(o_done), 64'd0);
  endtask

  vec_t tbl[7];
  vec_t v;

  initial begin
    int k;
    tbl[0] = '{1'b0, 2'd2, 32'h0000_1000, 32'h0, 32'h4433_2211,
               0, 1'b0, 32'h4433_2211, 8};
    tbl[1] = '{1'b1, 2'd1, 32'h0000_FFFF, 32'h0000_BEEF, 32'h0,
               3, 1'b0, 32'h0, 10};
    tbl[2] = '{1'b0, 2'd0, 32'hFFFF_FFFF, 32'h0, 32'h0000_005A,
               0, 1'b0, 32'h0000_005A, 2};
    tbl[3] = '{1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0, 32'h0000_A55A,
               0, 1'b0, 32'h0000_A55A, 4};
    tbl[4] = '{1'b0, 2'd3, 32'h0000_0200, 32'h0, 32'h0,
               0, 1'b1, 32'h0, 0};
    tbl[5] = '{1'b1, 2'd2, 32'h0000_0020, 32'h1234_5678, 32'h0,
               1, 1'b0, 32'h0, 12};
    tbl[6] = '{1'b0, 2'd1, 32'h0000_0008, 32'h0, 32'hDEAD_BEEF,
               2, 1'b0, 32'h0000_BEEF, 8};

    i_rst = 1'b1;
    i_req = 1'b0;
    i_we = 1'b0;
    i_size = 2'd0;
    i_addr = '0;
    i_wdata = '0;
    i_bus_data = '0;
    i_bus_data_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_strobe", 64'(o_bus_clk), 64'd0);
    chk("rst_addr", 64'(o_bus_addr), 64'd0);
    chk("rst_rdata", 64'(o_rdata), 64'd0);
    @(negedge clk);
    i_rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run(tbl[i], $sformatf("vec%0d", i));

    // Slave that never answers: abort exactly TIMEOUT cycles after the strobe edge.
    hang = 1;
    v = '{1'b0, 2'd0, 32'h0000_0040, 32'h0, 32'h0000_0077,
          0, 1'b1, 32'h0, 255};
    run(v, "timeout");
    hang = 0;

    // Reset in the middle of the second beat of a 4-byte store.
    v = '{1'b1, 2'd2, 32'h0000_0100, 32'hCAFE_F00D, 32'h0,
          2, 1'b0, 32'h0, 16};
    nseen = 0;
    drive(v);
    k = 0;
    while (nseen < 2 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("rst_mid_beat2", 64'(nseen), 64'd2);
    #2;
    i_rst = 1'b1;
    #1;
    chk("rst_mid_busy", 64'(o_busy), 64'd0);
    chk("rst_mid_strobe", 64'(o_bus_clk), 64'd0);
    chk("rst_mid_addr", 64'(o_bus_addr), 64'd0);
    chk("rst_mid_we", 64'(o_bus_we), 64'd0);
    chk("rst_mid_data", 64'(o_bus_data), 64'd0);
    bq.delete();
    @(negedge clk);
    i_rst = 1'b0;
    k = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (o_done) k++;
    end
    chk("rst_mid_no_done", 64'(k), 64'd0);
    run(tbl[0], "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
